// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: holds the architectural PC, issues one fetch at a time,
// hands the instruction to decode and waits for writeback to return the next PC.
//
// state   | meaning
// S_REQ   | fetch request presented at pc, waiting for memory to accept
// S_WAIT  | request accepted, waiting for the response word
// S_OUT   | instruction presented to decode
// S_WB    | waiting for writeback to deliver the resolved next PC
// S_FAULT | bus error or misaligned target seen; only reset leaves
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  output logic            imem_resp_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [XLEN-1:0] dnpc,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_OUT   = 3'd2,
    S_WB    = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            fault_q;
  logic            req_valid_q;
  logic            resp_ready_q;
  logic            inst_valid_q;
  logic            wb_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= XLEN'(RESET_PC);
      inst_q       <= '0;
      fault_q      <= 1'b0;
      req_valid_q  <= 1'b1;
      resp_ready_q <= 1'b0;
      inst_valid_q <= 1'b0;
      wb_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_q      <= S_WAIT;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            resp_ready_q <= 1'b0;
            if (imem_resp_err) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              inst_q       <= imem_rdata;
              inst_valid_q <= 1'b1;
              state_q      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            wb_ready_q   <= 1'b1;
            state_q      <= S_WB;
          end
        end
        S_WB: begin
          if (wb_valid) begin
            // pc takes dnpc even when misaligned so the bad target is visible
            pc_q       <= dnpc;
            wb_ready_q <= 1'b0;
            if (dnpc[1:0] != 2'b00) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= S_REQ;
            end
          end
        end
        default: begin
          state_q      <= S_FAULT;
          fault_q      <= 1'b1;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          inst_valid_q <= 1'b0;
          wb_ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs are forced low for the whole time rst is held
  assign imem_req_valid  = req_valid_q  & ~rst;
  assign imem_resp_ready = resp_ready_q & ~rst;
  assign inst_valid      = inst_valid_q & ~rst;
  assign wb_ready        = wb_ready_q   & ~rst;

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign snpc        = pc_q + XLEN'(4);
  assign inst        = inst_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0, imem_resp_ready;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, pc, snpc;
  logic        wb_valid = 1'b0, wb_ready;
  logic [31:0] dnpc = '0;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;

  ifu_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_ready(imem_resp_ready),
    .imem_rdata(imem_rdata), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .snpc(snpc),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .dnpc(dnpc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Model: which handshake of the 4-step instruction cycle is awaited next
  // (0 request, 1 response, 2 decode, 3 writeback), plus architectural values.
  int          m_next;
  logic [31:0] m_pc, m_inst;
  logic        m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_next = 0; m_pc = RST_PC; m_inst = '0; m_fault = 1'b0;
    end else if (!m_fault) begin
      if (m_next == 0 && imem_req_ready) m_next = 1;
      else if (m_next == 1 && imem_resp_valid) begin
        if (imem_resp_err) m_fault = 1'b1;
        else begin m_inst = imem_rdata; m_next = 2; end
      end else if (m_next == 2 && inst_ready) m_next = 3;
      else if (m_next == 3 && wb_valid) begin
        m_pc = dnpc;
        if (dnpc[1:0] != 2'b00) m_fault = 1'b1;
        else m_next = 0;
      end
    end
  endtask

  task automatic compare();
    logic live;
    live = !rst && !m_fault;
    check("req_valid",  {31'd0, imem_req_valid},  {31'd0, live && m_next == 0});
    check("resp_ready", {31'd0, imem_resp_ready}, {31'd0, live && m_next == 1});
    check("inst_valid", {31'd0, inst_valid},      {31'd0, live && m_next == 2});
    check("wb_ready",   {31'd0, wb_ready},        {31'd0, live && m_next == 3});
    check("imem_addr",  imem_addr, m_pc);
    check("pc",         pc, m_pc);
    check("snpc",       snpc, m_pc + 32'd4);
    check("inst",       inst, m_inst);
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  logic [31:0] saved;
  logic [31:0] r;

  initial begin
    cyc();
    check("reset_fault", {31'd0, fetch_fault}, 32'd0);

    // Zero-wait memory, all downstream readies high
    rst = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b1; imem_rdata = 32'h0000_0013;
    inst_ready = 1'b1; wb_valid = 1'b1; dnpc = 32'h8000_0004;
    #1;
    check("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("c1_addr", imem_addr, 32'h8000_0000);
    cycn(2);
    check("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("c3_inst", inst, 32'h0000_0013);
    cycn(2);
    check("c5_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("c5_addr", imem_addr, 32'h8000_0004);

    // Memory stalls: request held stable, response delayed
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_addr", imem_addr, 32'h8000_0004);
    end
    imem_req_ready = 1'b1;
    cycn(3);
    check("wait_no_second_req", {31'd0, imem_req_valid}, 32'd0);
    saved = $urandom; imem_rdata = saved; imem_resp_valid = 1'b1;
    dnpc = 32'h8000_0100;
    cyc();
    check("stall_inst", inst, saved);

    // Redirect
    cycn(2);
    check("redir_addr", imem_addr, 32'h8000_0100);
    check("redir_pc", pc, 32'h8000_0100);
    check("redir_snpc", snpc, 32'h8000_0104);

    // Wrap-around of snpc
    dnpc = 32'hFFFF_FFFC;
    cycn(4);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_snpc", snpc, 32'h0000_0000);

    // Misaligned target
    dnpc = 32'h8000_0102;
    cycn(4);
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_pc", pc, 32'h8000_0102);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    check("mis_rst_addr", imem_addr, 32'h8000_0000);
    check("mis_rst_fault", {31'd0, fetch_fault}, 32'd0);
    check("mis_rst_req", {31'd0, imem_req_valid}, 32'd1);

    // Bus error on the response
    imem_resp_err = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cycn(2);
    check("err_fault", {31'd0, fetch_fault}, 32'd1);
    check("err_inst", inst, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("err_no_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_resp_err = 1'b0;

    // Reset while waiting for a response, then stale response during REQ
    rst = 1'b1; cyc(); rst = 1'b0;
    imem_resp_valid = 1'b0; imem_req_ready = 1'b1;
    cyc();
    check("rw_in_wait", {31'd0, imem_resp_ready}, 32'd1);
    rst = 1'b1; cyc(); rst = 1'b0;
    imem_resp_valid = 1'b1; imem_req_ready = 1'b0; imem_rdata = 32'h1234_5678;
    #1;
    check("rw_resp_ready", {31'd0, imem_resp_ready}, 32'd0);
    check("rw_addr", imem_addr, 32'h8000_0000);
    cycn(2);
    check("rw_still_req", {31'd0, imem_req_valid}, 32'd1);
    check("rw_inst", inst, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready  = ($urandom_range(0, 3) != 0);
      imem_resp_valid = ($urandom_range(0, 2) != 0);
      imem_rdata      = $urandom;
      imem_resp_err   = ($urandom_range(0, 59) == 0);
      inst_ready      = ($urandom_range(0, 2) != 0);
      wb_valid        = ($urandom_range(0, 2) != 0);
      r = $urandom;
      if ($urandom_range(0, 19) != 0) r[1:0] = 2'b00;
      dnpc = r;
      rst = ($urandom_range(0, 149) == 0) || (m_fault && $urandom_range(0, 7) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch unit for the multicycle core; the consumer end of the next-PC path.
- Holds the architectural PC register and issues one instruction-fetch request per instruction over a valid/ready memory interface.
- Presents the fetched instruction with its PC and sequential next PC (snpc) to decode.
- Waits for writeback to return the resolved next PC (dnpc: jump, branch, ecall/mtvec or mret/mepc target), then loads it and starts the next fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction data.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  XLEN  fetch address; equals pc.
- imem_resp_valid  input  1  fetch data valid.
- imem_resp_ready  output  1  IFU accepts response.
- imem_rdata  input  XLEN  fetched instruction word.
- imem_resp_err  input  1  bus error qualifying the response.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  XLEN  latched instruction.
- pc  output  XLEN  PC of inst.
- snpc  output  XLEN  pc+4, modulo 2^XLEN.
- wb_valid  input  1  writeback presents resolved next PC.
- wb_ready  output  1  IFU accepts dnpc.
- dnpc  input  XLEN  resolved next PC.
- fetch_fault  output  1  sticky fault flag (misaligned dnpc or bus error).

Behaviour:
- States: REQ, WAIT, OUT, WB, FAULT. Exactly one state is active; all handshakes fire only when valid and ready are both high in the same cycle.
- Reset (rst=1 at posedge):
  - state<=REQ, pc<=RESET_PC, inst<=0, fetch_fault<=0.
  - While rst is high, imem_req_valid, imem_resp_ready, inst_valid and wb_ready are all 0.
  - Reset overrides any in-progress transaction in any state. Any memory response arriving after reset is dropped, because resp_ready=0 outside WAIT.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - Request handshake -> WAIT.
  - Otherwise stay, holding valid and addr stable.
- WAIT:
  - imem_resp_ready=1.
  - On response handshake with err=0: inst<=imem_rdata, go to OUT.
  - On response handshake with err=1: fetch_fault<=1, go to FAULT.
  - A response asserted during REQ (before the request handshake) is ignored.
- OUT:
  - inst_valid=1; inst, pc and snpc stay stable.
  - Handshake -> WB.
- WB:
  - wb_ready=1.
  - On handshake: pc<=dnpc.
  - If dnpc[1:0]!=0: fetch_fault<=1, go to FAULT. pc still takes dnpc, for debug visibility.
  - Otherwise go to REQ.
- FAULT:
  - All valid and ready outputs are 0; fetch_fault=1.
  - Only rst exits this state.
- Outputs:
  - snpc is combinational from pc.
  - pc changes only on reset or on the WB handshake.
  - inst changes only on reset or on a WAIT response handshake with err=0.
- Latency:
  - Minimum 4 cycles per instruction (REQ, WAIT, OUT, WB), with zero-wait memory and all downstream readies held high.
  - Each stall adds cycles 1:1.
- Every transaction is single-outstanding: no second request is issued before the WB handshake.
- Wrap-around: pc=32'hFFFF_FFFC gives snpc=32'h0000_0000.

Test Plan:
- Reset then zero-wait memory returning 32'h0000_0013, inst_ready=1, wb_valid=1 with dnpc=32'h8000_0004 -> imem_addr=32'h8000_0000 in cycle 1, inst_valid in cycle 3, and next request with addr 32'h8000_0004 in cycle 5.
- imem_req_ready low for 3 cycles, then resp_valid delayed 2 cycles -> req_valid and addr held stable, only one request accepted, inst matches rdata.
- Redirect: wb dnpc=32'h8000_0100 (jump/mtvec target) -> next imem_addr=32'h8000_0100, pc=32'h8000_0100, snpc=32'h8000_0104.
- Misaligned dnpc=32'h8000_0102 -> fetch_fault=1, no further req_valid until rst; rst then restarts fetch at 32'h8000_0000 with fault cleared.
- Response with imem_resp_err=1 -> fetch_fault=1, inst_valid never asserted, inst unchanged.
- rst asserted in WAIT, with resp_valid arriving the cycle after reset -> response not accepted; the new REQ uses addr 32'h8000_0000; a stale resp_valid while in REQ is ignored.
